// File: rtl/knn_vote_stage.sv
// k-nearest-neighbour vote stage: keeps the K_CONST closest {distance,label} candidates of a
// frame, votes on their labels and emits one predicted-label word per frame.
module knn_vote_stage #(
    parameter int unsigned K_CONST    = 3,
    parameter int unsigned NUM_CAND   = 30,
    parameter int unsigned DIST_BITS  = 8,
    parameter int unsigned LABEL_BITS = 4,
    parameter int unsigned NUM_LABELS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [31:0] Input_1_V_TDATA,
    input  logic        Input_1_V_TVALID,
    output logic        Input_1_V_TREADY,
    output logic [31:0] Output_1_V_TDATA,
    output logic        Output_1_V_TVALID,
    input  logic        Output_1_V_TREADY
);

    localparam int unsigned CntW  = $clog2(NUM_CAND + 1);
    localparam int unsigned VoteW = $clog2(K_CONST + 1);

    typedef enum logic [1:0] {StCollect, StVote1, StVote2, StSend} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [LABEL_BITS-1:0]  out_data_q, out_data_d;
    logic                   done_q, done_d;
    logic [DIST_BITS-1:0]   dist_q [K_CONST];
    logic [DIST_BITS-1:0]   dist_d [K_CONST];
    logic [LABEL_BITS-1:0]  label_q [K_CONST];
    logic [LABEL_BITS-1:0]  label_d [K_CONST];
    logic [DIST_BITS-1:0]   ins_dist [K_CONST];
    logic [LABEL_BITS-1:0]  ins_label [K_CONST];
    logic [VoteW-1:0]       vote_q [NUM_LABELS];
    logic [VoteW-1:0]       vote_d [NUM_LABELS];
    logic [K_CONST-1:0]     gt;
    logic [DIST_BITS-1:0]   in_dist;
    logic [LABEL_BITS-1:0]  in_label;
    logic [LABEL_BITS-1:0]  best_label;
    logic [VoteW-1:0]       best_cnt;
    logic                   accept;
    logic                   unused_tdata;

    assign in_dist      = Input_1_V_TDATA[DIST_BITS-1:0];
    assign in_label     = Input_1_V_TDATA[DIST_BITS +: LABEL_BITS];
    assign unused_tdata = ^Input_1_V_TDATA[31:DIST_BITS+LABEL_BITS];
    assign accept       = (state_q == StCollect) && in_ready_q && Input_1_V_TVALID;

    // Sorted insert: gt is monotone over a sorted list, so the new word lands at the first set bit.
    always_comb begin
        for (int unsigned k = 0; k < K_CONST; k++) begin
            gt[k]        = dist_q[k] > in_dist;
            ins_dist[k]  = dist_q[k];
            ins_label[k] = label_q[k];
            if (gt[k]) begin
                if (k == 0 || !gt[k-1]) begin
                    ins_dist[k]  = in_dist;
                    ins_label[k] = in_label;
                end else begin
                    ins_dist[k]  = dist_q[k-1];
                    ins_label[k] = label_q[k-1];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned l = 0; l < NUM_LABELS; l++) begin
            vote_d[l] = '0;
            for (int unsigned k = 0; k < K_CONST; k++) begin
                if (32'(label_q[k]) == l) begin
                    vote_d[l] = vote_d[l] + VoteW'(1);
                end
            end
        end
    end

    // Strict '>' keeps the lowest label on ties and yields label 0 when nothing voted.
    always_comb begin
        best_label = '0;
        best_cnt   = '0;
        for (int unsigned l = 0; l < NUM_LABELS; l++) begin
            if (vote_q[l] > best_cnt) begin
                best_cnt   = vote_q[l];
                best_label = LABEL_BITS'(l);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        dist_d      = dist_q;
        label_d     = label_q;
        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    dist_d  = ins_dist;
                    label_d = ins_label;
                    if (cnt_q == CntW'(NUM_CAND - 1)) begin
                        cnt_d      = '0;
                        in_ready_d = 1'b0;
                        state_d    = StVote1;
                    end else begin
                        cnt_d      = cnt_q + CntW'(1);
                        in_ready_d = 1'b1;
                    end
                end else begin
                    in_ready_d = (cnt_q != '0) || ap_start;
                end
            end
            StVote1: begin
                state_d = StVote2;
            end
            StVote2: begin
                out_data_d  = best_label;
                out_valid_d = 1'b1;
                state_d     = StSend;
            end
            StSend: begin
                if (Output_1_V_TREADY) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    in_ready_d  = ap_start;
                    state_d     = StCollect;
                    for (int unsigned k = 0; k < K_CONST; k++) begin
                        dist_d[k]  = '1;
                        label_d[k] = '1;
                    end
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StCollect;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            for (int unsigned k = 0; k < K_CONST; k++) begin
                dist_q[k]  <= '1;
                label_q[k] <= '1;
            end
            for (int unsigned l = 0; l < NUM_LABELS; l++) begin
                vote_q[l] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            dist_q      <= dist_d;
            label_q     <= label_d;
            if (state_q == StVote1) begin
                vote_q <= vote_d;
            end
        end
    end

    assign Input_1_V_TREADY  = in_ready_q;
    assign Output_1_V_TVALID = out_valid_q;
    assign Output_1_V_TDATA  = {{(32 - LABEL_BITS){1'b0}}, out_data_q};
    assign ap_done           = done_q;
    assign ap_ready          = done_q;
    assign ap_idle           = (state_q == StCollect) && (cnt_q == '0);

endmodule

// File: tb/tb_knn_vote_stage.sv
// Directed bench for knn_vote_stage with K_CONST=3, NUM_CAND=6.
module tb_knn_vote_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [31:0] in_tdata;
    logic        in_tvalid, in_tready;
    logic [31:0] out_tdata;
    logic        out_tvalid, out_tready;

    int n_cmp  = 0;
    int n_fail = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    knn_vote_stage #(
        .K_CONST    (3),
        .NUM_CAND   (6),
        .DIST_BITS  (8),
        .LABEL_BITS (4),
        .NUM_LABELS (10)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ap_start          (ap_start),
        .ap_done           (ap_done),
        .ap_idle           (ap_idle),
        .ap_ready          (ap_ready),
        .Input_1_V_TDATA   (in_tdata),
        .Input_1_V_TVALID  (in_tvalid),
        .Input_1_V_TREADY  (in_tready),
        .Output_1_V_TDATA  (out_tdata),
        .Output_1_V_TVALID (out_tvalid),
        .Output_1_V_TREADY (out_tready)
    );

    // Words listed in arrival order: index 5 arrives first.
    typedef struct {
        string           name;
        logic [5:0][7:0] d;
        logic [5:0][3:0] l;
        logic [31:0]     exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upper bits carry junk that the DUT must ignore.
    task automatic send_word(input logic [7:0] d, input logic [3:0] l);
        int n = 0;
        in_tvalid = 1'b1;
        in_tdata  = {20'hABCDE, l, d};
        while (!in_tready && n < 50) begin
            tick();
            n++;
        end
        stall_cnt += n;
        if (!in_tready) begin
            n_fail++;
            $display("FAIL accept_timeout: got tready=0 expected 1");
        end
        tick();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!out_tvalid && n < 20);
        check({name, "_latency"}, n, 2);
    endtask

    task automatic handshake(input string name);
        out_tready = 1'b1;
        tick();
        out_tready = 1'b0;
        check({name, "_tvalid_drop"}, {31'd0, out_tvalid}, 0);
        check({name, "_ap_done"}, {30'd0, ap_done, ap_ready}, 3);
        tick();
        check({name, "_ap_done_pulse"}, {31'd0, ap_done}, 0);
    endtask

    task automatic send_frame(input vec_t v);
        stall_cnt = 0;
        for (int i = 5; i >= 0; i--) send_word(v.d[i], v.l[i]);
        in_tvalid = 1'b0;
        check({v.name, "_back_to_back"}, stall_cnt, 0);
        wait_valid(v.name);
        check({v.name, "_tdata"}, out_tdata, v.exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"nearest_majority", {8'd1, 8'd2, 8'd3, 8'd7, 8'd8, 8'd9},
                    {4'd5, 4'd5, 4'd0, 4'd5, 4'd8, 4'd9}, 32'd5};
        vecs[1] = '{"three_way_tie", {8'd5, 8'd9, 8'd3, 8'd4, 8'd200, 8'd4},
                    {4'd2, 4'd7, 4'd2, 4'd7, 4'd1, 4'd1}, 32'd1};
        vecs[2] = '{"invalid_labels", {8'd0, 8'd1, 8'd2, 8'd50, 8'd50, 8'd50},
                    {4'd12, 4'd13, 4'd14, 4'd3, 4'd3, 4'd3}, 32'd0};
        vecs[3] = '{"equal_dist_order", {8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4},
                    {4'd6, 4'd2, 4'd2, 4'd6, 4'd6, 4'd6}, 32'd2};
        vecs[4] = '{"max_dist_ignored", {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255},
                    {4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7}, 32'd0};
        vecs[5] = '{"descending", {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4},
                    {4'd1, 4'd1, 4'd3, 4'd3, 4'd3, 4'd9}, 32'd3};

        reset      = 1'b1;
        ap_start   = 1'b1;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        out_tready = 1'b0;

        tick();
        check("reset_tready", {31'd0, in_tready}, 0);
        check("reset_tvalid", {31'd0, out_tvalid}, 0);
        check("reset_tdata", out_tdata, 0);
        check("reset_idle", {31'd0, ap_idle}, 1);
        check("reset_done", {31'd0, ap_done}, 0);
        reset = 1'b0;
        tick();
        check("post_reset_tready", {31'd0, in_tready}, 1);

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v]);
            handshake(vecs[v].name);
        end

        // Output back-pressure: result held, input stalled.
        send_frame(vecs[0]);
        for (int i = 0; i < 10; i++) begin
            check("stall_tvalid", {31'd0, out_tvalid}, 1);
            check("stall_tdata", out_tdata, 5);
            check("stall_in_tready", {31'd0, in_tready}, 0);
            tick();
        end
        out_tready = 1'b1;
        tick();
        out_tready = 1'b0;
        check("stall_done", {31'd0, ap_done}, 1);
        check("stall_in_tready_back", {31'd0, in_tready}, 1);
        tick();
        check("stall_done_pulse", {31'd0, ap_done}, 0);
        send_frame(vecs[1]);
        handshake("after_stall");

        // Reset mid-frame: the closer partial words must not survive.
        for (int i = 0; i < 3; i++) send_word(8'd0, 4'd7);
        in_tvalid = 1'b0;
        check("partial_not_idle", {31'd0, ap_idle}, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_tready", {31'd0, in_tready}, 0);
        check("midreset_idle", {31'd0, ap_idle}, 1);
        tick();
        begin
            vec_t r;
            r = '{"after_reset", {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1},
                  {4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4}, 32'd4};
            send_frame(r);
            handshake(r.name);
        end

        // No new frame without ap_start.
        ap_start = 1'b0;
        tick();
        tick();
        check("no_start_tready", {31'd0, in_tready}, 0);
        check("no_start_idle", {31'd0, ap_idle}, 1);
        ap_start = 1'b1;
        tick();
        check("restart_tready", {31'd0, in_tready}, 1);
        send_frame(vecs[5]);
        handshake("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
